operand_sequencer: RTL and testbench

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/sumador_pkg.sv | 25 ++
 rtl/button_debouncer.sv | 50 +++++
 rtl/operand_sequencer.sv | 105 ++++++++++
 tb/tb_operand_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sumador_pkg.sv
// Shared types and defaults for the operand sequencer: FSM state encoding,
// default debounce length and the 9-bit add/subtract helper.
package sumador_pkg;

    // State encodings double as the LED phase output.
    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    // Bit 8 is carry for add and borrow for subtract. A zero-extended
    // subtraction sets bit 8 exactly when a < b.
    function automatic logic [8:0] alu9(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic       sub);
        if (sub)
            return {1'b0, a} - {1'b0, b};
        else
            return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop synchronizer -> stable-level debouncer -> one-cycle
// press pulse on each accepted 0->1 change.
module button_debouncer
    import sumador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    // The counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_level_q;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    // Synchronize, count consecutive disagreeing cycles, accept the new level
    // on the last one, then register the rising-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt     <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], raw};
            r_level_q <= r_level;
            r_pulse   <= r_level & ~r_level_q;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/operand_sequencer.sv
// Two-operand add/subtract sequencer driven by debounced enter/clear buttons.
// LOAD_A and LOAD_B echo the switches; SHOW freezes the computed result.
module operand_sequencer
    import sumador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       mode,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [7:0] value,
    output logic       carry,
    output logic [1:0] phase
);

    logic       w_enter;
    logic       w_clear;
    logic [8:0] w_res;

    state_t     r_state;
    logic [7:0] r_a;
    logic [8:0] r_result;
    logic [7:0] r_value;
    logic       r_carry;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_enter),
        .pulse (w_enter)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clear),
        .pulse (w_clear)
    );

    // B is consumed in the same cycle it is captured, so the result register
    // is its only storage.
    assign w_res = alu9(r_a, sw, mode);

    // Sequencer FSM with registered display outputs; clear outranks enter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOAD_A;
            r_a      <= '0;
            r_result <= '0;
            r_value  <= '0;
            r_carry  <= 1'b0;
        end else if (w_clear) begin
            r_state  <= LOAD_A;
            r_a      <= '0;
            r_result <= '0;
            r_value  <= sw;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    r_value <= sw;
                    r_carry <= 1'b0;
                    if (w_enter) begin
                        r_a     <= sw;
                        r_state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (w_enter) begin
                        r_result <= w_res;
                        r_value  <= w_res[7:0];
                        r_carry  <= w_res[8];
                        r_state  <= SHOW;
                    end else begin
                        r_value <= sw;
                        r_carry <= 1'b0;
                    end
                end
                SHOW: begin
                    if (w_enter) begin
                        r_value <= sw;
                        r_carry <= 1'b0;
                        r_state <= LOAD_A;
                    end else begin
                        r_value <= r_result[7:0];
                        r_carry <= r_result[8];
                    end
                end
                default: begin
                    r_value <= sw;
                    r_carry <= 1'b0;
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

    assign value = r_value;
    assign carry = r_carry;
    assign phase = r_state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer with a short debounce period: pulse timing,
// bounce rejection, arithmetic against an integer reference, clear priority
// and reset behaviour.
module tb_operand_sequencer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic       mode;
    logic       btn_enter;
    logic       btn_clear;
    logic [7:0] value;
    logic       carry;
    logic [1:0] phase;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .mode      (mode),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .value     (value),
        .carry     (carry),
        .phase     (phase)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference arithmetic from plain integers.
    function automatic logic [8:0] ref_op(input int a, input int b, input bit sub);
        int r;
        r = sub ? a - b : a + b;
        if (sub)
            return {(a < b) ? 1'b1 : 1'b0, 8'((r + 256) % 256)};
        else
            return {(r > 255) ? 1'b1 : 1'b0, 8'(r % 256)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the selected buttons long enough for one pulse, then release fully.
    task automatic press(input bit ent, input bit clr);
        btn_enter = ent;
        btn_clear = clr;
        repeat (D + 6) tick();
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (D + 6) tick();
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit sub,
                          input string name);
        logic [8:0] exp;
        exp = ref_op(int'(a), int'(b), sub);
        press(1'b0, 1'b1);
        sw = a;
        press(1'b1, 1'b0);
        checks++;
        if (phase !== 2'b01) begin
            errors++;
            $display("FAIL %s phaseB: got %b expected 01", name, phase);
        end
        sw   = b;
        mode = sub;
        press(1'b1, 1'b0);
        checks++;
        if (phase !== 2'b10 || value !== exp[7:0] || carry !== exp[8]) begin
            errors++;
            $display("FAIL %s result: got phase=%b value=%h carry=%b expected phase=10 value=%h carry=%b",
                     name, phase, value, carry, exp[7:0], exp[8]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sw = 8'hA5; mode = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
        tick(); tick();
        checks++;
        if (value !== 8'h00 || carry !== 1'b0 || phase !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got value=%h carry=%b phase=%b expected 00/0/00", value, carry, phase);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (value !== 8'hA5) begin
            errors++;
            $display("FAIL reset_echo: got value=%h expected a5", value);
        end
    endtask

    task automatic test_enter_timing();
        int n;
        btn_enter = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (dut.u_enter.pulse !== (i == 7)) begin
                errors++;
                $display("FAIL enter_pulse_cycle%0d: got %b expected %b", i, dut.u_enter.pulse, (i == 7));
            end
        end
        btn_enter = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dut.u_enter.pulse === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL release_pulse: got %0d pulses expected 0", n);
        end
        checks++;
        if (phase !== 2'b01) begin
            errors++;
            $display("FAIL single_step: got phase=%b expected 01", phase);
        end
        press(1'b0, 1'b1);
    endtask

    task automatic test_bounce();
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            btn_enter = ((i / 2) % 2 == 0);
            tick();
            if (dut.u_enter.pulse === 1'b1) n++;
        end
        checks++;
        if (n != 0 || phase !== 2'b00) begin
            errors++;
            $display("FAIL bounce_reject: got %0d pulses phase=%b expected 0 pulses phase=00", n, phase);
        end
        btn_enter = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (dut.u_enter.pulse !== (i == 7)) begin
                errors++;
                $display("FAIL bounce_settle_cycle%0d: got %b expected %b", i, dut.u_enter.pulse, (i == 7));
            end
        end
        btn_enter = 1'b0;
        repeat (12) tick();
        press(1'b0, 1'b1);
    endtask

    task automatic test_add_and_hold();
        logic [7:0] s;
        press(1'b0, 1'b1);
        sw = 8'h3C; mode = 1'b0;
        tick();
        checks++;
        if (value !== 8'h3C || carry !== 1'b0 || phase !== 2'b00) begin
            errors++;
            $display("FAIL loadA_echo: got value=%h carry=%b phase=%b expected 3c/0/00", value, carry, phase);
        end
        press(1'b1, 1'b0);
        checks++;
        if (phase !== 2'b01) begin
            errors++;
            $display("FAIL add_phaseB: got %b expected 01", phase);
        end
        sw = 8'h0F;
        tick();
        checks++;
        if (value !== 8'h0F || carry !== 1'b0) begin
            errors++;
            $display("FAIL loadB_echo: got value=%h carry=%b expected 0f/0", value, carry);
        end
        press(1'b1, 1'b0);
        checks++;
        if (phase !== 2'b10 || value !== 8'h4B || carry !== 1'b0) begin
            errors++;
            $display("FAIL add_3c_0f: got phase=%b value=%h carry=%b expected 10/4b/0", phase, value, carry);
        end
        for (int i = 0; i < 4; i++) begin
            sw = 8'($urandom); mode = 1'($urandom);
            tick();
        end
        checks++;
        if (value !== 8'h4B || carry !== 1'b0) begin
            errors++;
            $display("FAIL show_hold: got value=%h carry=%b expected 4b/0", value, carry);
        end
        s = 8'($urandom);
        sw = s;
        press(1'b1, 1'b0);
        checks++;
        if (phase !== 2'b00 || value !== s || carry !== 1'b0) begin
            errors++;
            $display("FAIL show_to_loadA: got phase=%b value=%h carry=%b expected 00/%h/0", phase, value, carry, s);
        end
    endtask

    task automatic test_boundaries();
        run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        run_op(8'h10, 8'h20, 1'b1, "sub_10_20");
        run_op(8'h00, 8'h01, 1'b1, "sub_00_01");
        run_op(8'h55, 8'h55, 1'b1, "sub_equal");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), "random_op");
    endtask

    task automatic test_clear_priority();
        logic [7:0] s;
        press(1'b0, 1'b1);
        sw = 8'h22;
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        s = 8'($urandom);
        sw = s;
        tick();
        checks++;
        if (phase !== 2'b00 || value !== s || carry !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority: got phase=%b value=%h carry=%b expected 00/%h/0", phase, value, carry, s);
        end
        run_op(8'hF0, 8'h20, 1'b0, "pre_clear_show");
        s = 8'($urandom);
        sw = s;
        press(1'b0, 1'b1);
        checks++;
        if (phase !== 2'b00 || value !== s || carry !== 1'b0) begin
            errors++;
            $display("FAIL clear_from_show: got phase=%b value=%h carry=%b expected 00/%h/0", phase, value, carry, s);
        end
    endtask

    task automatic test_reset_mid();
        run_op(8'h80, 8'h90, 1'b0, "pre_reset_show");
        btn_enter = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (phase !== 2'b00 || carry !== 1'b0 || value !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_show: got phase=%b carry=%b value=%h expected 00/0/00", phase, carry, value);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (dut.u_enter.pulse !== (i == 7)) begin
                errors++;
                $display("FAIL reset_repress_cycle%0d: got %b expected %b", i, dut.u_enter.pulse, (i == 7));
            end
        end
        btn_enter = 1'b0;
        repeat (10) tick();
        checks++;
        if (phase !== 2'b01) begin
            errors++;
            $display("FAIL reset_repress_phase: got %b expected 01", phase);
        end
    endtask

    initial begin
        test_reset();
        test_enter_timing();
        test_bounce();
        test_add_and_hold();
        test_boundaries();
        test_random();
        test_clear_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
